arith_exec_unit: RTL and testbench

Multi-cycle, handshaked arithmetic execution unit for the 19-bit CPU. It takes one operation request at a time from the decode/issue stage and returns a registered result over a valid/ready response channel. ADD, SUB, INC and DEC complete in a single cycle. MUL and DIV run iteratively, so issue logic must stall on `req_ready` instead of relying on fixed timing.

---
 rtl/arith_exec_unit.sv | 186 ++++++++++++++++++
 tb/tb_arith_exec_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/arith_exec_unit.sv
// Multi-cycle handshaked arithmetic unit: 1-cycle ADD/SUB/INC/DEC, iterative MUL and DIV.
// Define ARITH_DIV_EN to build the restoring divider; otherwise DIV returns err=1.

package constants;
  localparam int WORD_SIZE   = 19;
  localparam int OPCODE_SIZE = 4;
endpackage

package opcodes;
  localparam logic [constants::OPCODE_SIZE-1:0] OP_ADD = 4'h0;
  localparam logic [constants::OPCODE_SIZE-1:0] OP_SUB = 4'h1;
  localparam logic [constants::OPCODE_SIZE-1:0] OP_INC = 4'h2;
  localparam logic [constants::OPCODE_SIZE-1:0] OP_DEC = 4'h3;
  localparam logic [constants::OPCODE_SIZE-1:0] OP_MUL = 4'h4;
  localparam logic [constants::OPCODE_SIZE-1:0] OP_DIV = 4'h5;
endpackage

module arith_exec_unit
  import constants::*;
  import opcodes::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPCODE_SIZE-1:0] req_opcode,
  input  logic [WORD_SIZE-1:0]   req_op1,
  input  logic [WORD_SIZE-1:0]   req_op2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_SIZE-1:0]   rsp_result,
  output logic [WORD_SIZE-1:0]   rsp_rem,
  output logic                   rsp_carry,
  output logic                   rsp_err
);

  localparam int CNT_W = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg;
  logic [OPCODE_SIZE-1:0]   opcode_reg;
  logic [WORD_SIZE-1:0]     op1_reg;
  logic [WORD_SIZE-1:0]     op2_reg;
  logic [2*WORD_SIZE-1:0]   acc_reg;
  logic [2*WORD_SIZE-1:0]   mcand_reg;
  logic                     rsp_valid_reg;
  logic [WORD_SIZE-1:0]     rsp_result_reg, rsp_rem_reg;
  logic                     rsp_carry_reg, rsp_err_reg;
  logic [WORD_SIZE-1:0]     result_next, rem_next;
  logic                     carry_next, err_next;
  logic                     iterative;

`ifdef ARITH_DIV_EN
  logic [WORD_SIZE-1:0]     rem_reg;
  logic [WORD_SIZE:0]       div_shift, div_diff;
  assign div_shift = {rem_reg, op1_reg[WORD_SIZE-1]};
  assign div_diff  = div_shift - {1'b0, op2_reg};
  assign iterative = (req_opcode == OP_MUL) || ((req_opcode == OP_DIV) && (req_op2 != '0));
`else
  assign iterative = (req_opcode == OP_MUL);
`endif

  assign req_ready  = (state_reg == IDLE);
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_rem    = rsp_rem_reg;
  assign rsp_carry  = rsp_carry_reg;
  assign rsp_err    = rsp_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = iterative ? BUSY : DONE;
      BUSY: if (cnt_reg == '0) state_next = DONE;
      DONE: if (rsp_valid_reg && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response values derived from the latched operands / finished iteration state.
  always_comb begin
    result_next = '0;
    rem_next    = '0;
    carry_next  = 1'b0;
    err_next    = 1'b0;
    case (opcode_reg)
      OP_ADD: {carry_next, result_next} = {1'b0, op1_reg} + {1'b0, op2_reg};
      OP_SUB: {carry_next, result_next} = {1'b0, op1_reg} - {1'b0, op2_reg};
      OP_INC: {carry_next, result_next} = {1'b0, op1_reg} + (WORD_SIZE+1)'(1);
      OP_DEC: {carry_next, result_next} = {1'b0, op1_reg} - (WORD_SIZE+1)'(1);
      OP_MUL: begin
        result_next = acc_reg[WORD_SIZE-1:0];
        carry_next  = |acc_reg[2*WORD_SIZE-1:WORD_SIZE];
      end
      OP_DIV: begin
`ifdef ARITH_DIV_EN
        if (op2_reg == '0) begin
          result_next = '1;
          rem_next    = op1_reg;
          err_next    = 1'b1;
        end else begin
          result_next = op1_reg;
          rem_next    = rem_reg;
        end
`else
        err_next = 1'b1;
`endif
      end
      default: err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      opcode_reg     <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      acc_reg        <= '0;
      mcand_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_rem_reg    <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
`ifdef ARITH_DIV_EN
      rem_reg        <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          opcode_reg <= req_opcode;
          op1_reg    <= req_op1;
          op2_reg    <= req_op2;
          acc_reg    <= '0;
          mcand_reg  <= {{WORD_SIZE{1'b0}}, req_op1};
          cnt_reg    <= CNT_W'(WORD_SIZE - 1);
`ifdef ARITH_DIV_EN
          rem_reg    <= '0;
`endif
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (opcode_reg == OP_MUL) begin
            // LSB-first shift-add: op2 shifts down, multiplicand shifts up
            if (op2_reg[0]) acc_reg <= acc_reg + mcand_reg;
            mcand_reg <= mcand_reg << 1;
            op2_reg   <= op2_reg >> 1;
          end
`ifdef ARITH_DIV_EN
          else begin
            // op1_reg doubles as the dividend/quotient shift register
            if (!div_diff[WORD_SIZE]) begin
              rem_reg <= div_diff[WORD_SIZE-1:0];
              op1_reg <= {op1_reg[WORD_SIZE-2:0], 1'b1};
            end else begin
              rem_reg <= div_shift[WORD_SIZE-1:0];
              op1_reg <= {op1_reg[WORD_SIZE-2:0], 1'b0};
            end
          end
`endif
        end
        DONE: begin
          if (!rsp_valid_reg) begin
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= result_next;
            rsp_rem_reg    <= rem_next;
            rsp_carry_reg  <= carry_next;
            rsp_err_reg    <= err_next;
          end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_exec_unit.sv
// Directed, table-driven bench for arith_exec_unit plus backpressure and mid-op reset sequences.
module tb_arith_exec_unit;
  import constants::*;
  import opcodes::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [OPCODE_SIZE-1:0] req_opcode = '0;
  logic [WORD_SIZE-1:0]   req_op1 = '0;
  logic [WORD_SIZE-1:0]   req_op2 = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [WORD_SIZE-1:0]   rsp_result;
  logic [WORD_SIZE-1:0]   rsp_rem;
  logic                   rsp_carry;
  logic                   rsp_err;

  arith_exec_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_rem(rsp_rem), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                  name;
    logic [OPCODE_SIZE-1:0] opc;
    logic [WORD_SIZE-1:0]   op1, op2, res, rem;
    logic                   carry, err;
    int                     lat;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [OPCODE_SIZE-1:0] opc, input logic [WORD_SIZE-1:0] a,
                       input logic [WORD_SIZE-1:0] b);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_opcode = opc;
    req_op1    = a;
    req_op2    = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 0;
    int ready_hi = 0;
    issue(v.opc, v.op1, v.op2);
    while (!rsp_valid && lat < 100) begin
      if (req_ready) ready_hi++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (req_ready) ready_hi++;
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_ready_low"}, 32'(ready_hi), 32'd0);
    check({v.name, "_result"}, 32'(rsp_result), 32'(v.res));
    check({v.name, "_rem"}, 32'(rsp_rem), 32'(v.rem));
    check({v.name, "_carry"}, 32'(rsp_carry), 32'(v.carry));
    check({v.name, "_err"}, 32'(rsp_err), 32'(v.err));
    $display("op %-10s op1=0x%05h op2=0x%05h -> res=0x%05h rem=0x%05h c=%0d e=%0d lat=%0d",
             v.name, v.op1, v.op2, rsp_result, rsp_rem, rsp_carry, rsp_err, lat);
    @(posedge clk);
    @(negedge clk);
    check({v.name, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
    check({v.name, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int stable_bad;
    int w;
    vecs.push_back('{"add", OP_ADD, 19'd10, 19'd5, 19'd15, 19'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{"inc", OP_INC, 19'd10, 19'd123, 19'd11, 19'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{"dec", OP_DEC, 19'd10, 19'd77, 19'd9, 19'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{"sub_wrap", OP_SUB, 19'd5, 19'd10, 19'h7FFFB, 19'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{"add_wrap", OP_ADD, 19'h7FFFF, 19'd1, 19'd0, 19'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{"inc_wrap", OP_INC, 19'h7FFFF, 19'd0, 19'd0, 19'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{"dec_wrap", OP_DEC, 19'd0, 19'd0, 19'h7FFFF, 19'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{"mul", OP_MUL, 19'd3, 19'd4, 19'd12, 19'd0, 1'b0, 1'b0, 20});
    vecs.push_back('{"mul_ovf", OP_MUL, 19'h400, 19'h400, 19'd0, 19'd0, 1'b1, 1'b0, 20});
    vecs.push_back('{"mul_max", OP_MUL, 19'h7FFFF, 19'h7FFFF, 19'd1, 19'd0, 1'b1, 1'b0, 20});
`ifdef ARITH_DIV_EN
    vecs.push_back('{"div", OP_DIV, 19'd20, 19'd4, 19'd5, 19'd0, 1'b0, 1'b0, 20});
    vecs.push_back('{"div_rem", OP_DIV, 19'd23, 19'd4, 19'd5, 19'd3, 1'b0, 1'b0, 20});
    vecs.push_back('{"div_max", OP_DIV, 19'h7FFFF, 19'd1, 19'h7FFFF, 19'd0, 1'b0, 1'b0, 20});
    vecs.push_back('{"div_zero", OP_DIV, 19'd7, 19'd0, 19'h7FFFF, 19'd7, 1'b0, 1'b1, 1});
`else
    vecs.push_back('{"div_off", OP_DIV, 19'd20, 19'd4, 19'd0, 19'd0, 1'b0, 1'b1, 1});
    vecs.push_back('{"div_zero", OP_DIV, 19'd7, 19'd0, 19'd0, 19'd0, 1'b0, 1'b1, 1});
`endif
    vecs.push_back('{"illegal", 4'hF, 19'd5, 19'd6, 19'd0, 19'd0, 1'b0, 1'b1, 1});

    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_outputs", 32'({rsp_result, rsp_rem, rsp_carry, rsp_err} != '0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: response held while rsp_ready is low, stray requests ignored
    rsp_ready = 1'b0;
    issue(OP_ADD, 19'd10, 19'd5);
    w = 0;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid  = (c % 2 == 0);
      req_opcode = OP_MUL;
      req_op1    = 19'd9;
      req_op2    = 19'd9;
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_result !== 19'd15 || rsp_carry || rsp_err || req_ready)
        stable_bad++;
    end
    req_valid = 1'b0;
    check("bp_stable_cycles", 32'(stable_bad), 32'd0);
    $display("op backpress held 10 cycles res=0x%05h unstable=%0d", rsp_result, stable_bad);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("bp_ready_back", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_no_ghost_op", 32'({rsp_valid, req_ready}), 32'b01);

    // Reset in the middle of a MUL discards it
    issue(OP_MUL, 19'd3, 19'd4);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_outputs", 32'({rsp_result, rsp_rem, rsp_carry, rsp_err} != '0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    $display("op mid_reset mul discarded rsp_valid=%0d req_ready=%0d", rsp_valid, req_ready);
    run_vec('{"add_after", OP_ADD, 19'd1, 19'd1, 19'd2, 19'd0, 1'b0, 1'b0, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
